// File: rtl/byte_en_dff_reg_if.sv
// Write-data/enable bus and registered read-back for one bit-enabled storage register.
// The master drives data and enables; the slave returns the stored contents.
interface byte_en_dff_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] i_data;
    logic [WIDTH-1:0] i_en;
    logic [WIDTH-1:0] o_data;

    modport master (
        output i_data,
        output i_en,
        input  o_data
    );

    modport slave (
        input  i_data,
        input  i_en,
        output o_data
    );
endinterface

// File: rtl/byte_en_dff_reg.sv
// Purpose: WIDTH-bit storage register with an independent write enable per bit.
// Latency: one clock from i_data/i_en to o_data; o_data is driven straight from the flops.
// Backpressure: none; a write is accepted on every rising edge with i_rst_n low.
module byte_en_dff_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                   i_clk,
    // Active-high despite the legacy name: 1 holds the register at RST_VAL.
    input  logic                   i_rst_n,
    byte_en_dff_reg_if.slave       bus
);

    logic [WIDTH-1:0] data_q;

    // Each bit gets its own flop and hold mux, so mixed enables touch only the enabled bits.
    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        logic bit_d;
        logic bit_q;

        always_comb begin
            bit_d = bit_q;
            if (bus.i_en[k]) begin
                bit_d = bus.i_data[k];
            end
        end

        always_ff @(posedge i_clk or posedge i_rst_n) begin
            if (i_rst_n) begin
                bit_q <= RST_VAL[k];
            end else begin
                bit_q <= bit_d;
            end
        end

        assign data_q[k] = bit_q;
    end

    assign bus.o_data = data_q;

endmodule

// File: tb/tb_byte_en_dff_reg.sv
// Directed checks of the bit-enabled register: a vector table for edge-by-edge behaviour,
// then hand sequences for asynchronous reset, release, and input changes between edges.
module tb_byte_en_dff_reg;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    byte_en_dff_reg_if #(.WIDTH(8)) bus ();

    byte_en_dff_reg #(
        .WIDTH   (8),
        .RST_VAL (8'h00)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [7:0] en;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: o_data=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, then sample 1 ns after the next rising edge.
    task automatic step(input logic r, input logic [7:0] en, input logic [7:0] data);
        @(negedge clk);
        rst        = r;
        bus.i_en   = en;
        bus.i_data = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst        = 1'b1;
        bus.i_en   = 8'h00;
        bus.i_data = 8'h00;

        // Reset dominance, capture after release, per-bit enables, hold, full load.
        vecs[0]  = '{1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[1]  = '{1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[2]  = '{1'b1, 8'hFF, 8'hFF, 8'h00};
        vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 8'hFF};
        vecs[4]  = '{1'b0, 8'hFF, 8'h01, 8'h01};
        vecs[5]  = '{1'b0, 8'hFF, 8'h3C, 8'h3C};
        vecs[6]  = '{1'b0, 8'hFF, 8'h00, 8'h00};
        vecs[7]  = '{1'b0, 8'h0F, 8'hFF, 8'h0F};
        vecs[8]  = '{1'b0, 8'hF0, 8'h00, 8'h0F};
        vecs[9]  = '{1'b0, 8'hF0, 8'hAA, 8'hAF};
        for (int i = 10; i < 18; i++) begin
            vecs[i] = '{1'b0, 8'h00, ((i % 2) == 0) ? 8'h55 : 8'hAA, 8'hAF};
        end
        vecs[18] = '{1'b0, 8'hFF, 8'hA5, 8'hA5};

        @(posedge clk);
        #1;
        check("reset_state", bus.o_data, 8'h00);

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].data);
            check($sformatf("vec%0d", i), bus.o_data, vecs[i].exp);
        end

        // Asynchronous assert between edges, o_data was A5.
        @(negedge clk);
        #2;
        bus.i_en = 8'hFF;
        bus.i_data = 8'h77;
        rst = 1'b1;
        #1;
        check("async_assert", bus.o_data, 8'h00);
        #1;
        rst = 1'b0;
        bus.i_en = 8'h00;
        #1;
        check("release_no_change", bus.o_data, 8'h00);
        @(posedge clk);
        #1;
        check("release_hold_edge", bus.o_data, 8'h00);

        // Mid-operation reset discards the loaded value for good.
        step(1'b0, 8'hFF, 8'h5A);
        check("load_5a", bus.o_data, 8'h5A);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midstream_assert", bus.o_data, 8'h00);
        #14;
        rst = 1'b0;
        bus.i_en = 8'h00;
        bus.i_data = 8'h5A;
        #1;
        check("midstream_release", bus.o_data, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("midstream_hold%0d", i), bus.o_data, 8'h00);
        end
        step(1'b0, 8'hFF, 8'hC3);
        check("midstream_enabled", bus.o_data, 8'hC3);

        // Input changes after an edge must not reach o_data before the next edge.
        step(1'b0, 8'hFF, 8'h11);
        check("load_11", bus.o_data, 8'h11);
        bus.i_data = 8'h22;
        #2;
        check("no_comb_data", bus.o_data, 8'h11);
        bus.i_en = 8'h00;
        bus.i_data = 8'hEE;
        #2;
        check("no_comb_en", bus.o_data, 8'h11);
        @(posedge clk);
        #1;
        check("en_off_hold", bus.o_data, 8'h11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
